// File: rtl/vx_tcu_drl_exp_align_pkg.sv
// Shared TCU exponent front-end definitions: format IDs, product rebias per format, NEG_INF.
package vx_tcu_drl_exp_align_pkg;

   typedef enum logic [2:0] {
      TCU_FP16 = 3'd1,
      TCU_BF16 = 3'd2,
      TCU_FP8  = 3'd3,
      TCU_BF8  = 3'd4,
      TCU_TF32 = 3'd5
   } tcu_fmt_e;

   localparam int                    EXP_W_DEF   = 10;
   localparam logic [EXP_W_DEF-1:0]  EXP_NEG_INF = {1'b1, {(EXP_W_DEF-1){1'b0}}};

   function automatic logic fmt_ok(input logic [2:0] fmt);
      return fmt inside {TCU_FP16, TCU_BF16, TCU_FP8, TCU_BF8, TCU_TF32};
   endfunction

   // Rebias of ea+eb into the common exponent domain; (wa - w) is the window headroom above the product MSB.
   function automatic int bias_of(input logic [2:0] fmt, input int w, input int wa);
      int b;
      case (fmt)
         TCU_FP16:           b = 97;
         TCU_BF8:            b = 98;
         TCU_FP8:            b = 114;
         TCU_BF16, TCU_TF32: b = -127;
         default:            b = 0;
      endcase
      return b + (wa - w);
   endfunction

endpackage

// File: rtl/vx_tcu_drl_exp_align_max_tree.sv
// Combinational signed maximum over N exponents; NEG_INF is the most negative code so it never wins.
module vx_tcu_drl_exp_max_tree #(
   parameter int N     = 9,
   parameter int EXP_W = 10
) (
   input  logic [N-1:0][EXP_W-1:0] i_exps,
   output logic [EXP_W-1:0]        o_max
);

   always_comb begin
      o_max = i_exps[0];
      for (int i = 1; i < N; i++)
         if ($signed(i_exps[i]) > $signed(o_max)) o_max = i_exps[i];
   end

endmodule

// File: rtl/vx_tcu_drl_exp_align.sv
// Pipelined TCU exponent front-end: S1 term exponents, S2 max reduction, S3 per-term shift/drop.
module vx_tcu_drl_exp_align
   import vx_tcu_drl_exp_align_pkg::*;
#(
   parameter int NUM_TERMS = 8,
   parameter int EXP_W     = 10,
   parameter int W         = 25,
   parameter int WA        = 28,
   parameter int SHIFT_W   = $clog2(WA) + 1,
   parameter int TAG_W     = 8
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [2:0]                        in_fmt,
   input  logic [NUM_TERMS-1:0][7:0]         in_ea,
   input  logic [NUM_TERMS-1:0][7:0]         in_eb,
   input  logic [NUM_TERMS-1:0]              in_zero,
   input  logic [7:0]                        in_c_exp,
   input  logic                              in_c_zero,
   input  logic [TAG_W-1:0]                  in_tag,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [EXP_W-1:0]                  out_max_exp,
   output logic [NUM_TERMS:0][SHIFT_W-1:0]   out_shift,
   output logic [NUM_TERMS:0]                out_drop,
   output logic                              out_all_zero,
   output logic                              out_fmt_err,
   output logic [TAG_W-1:0]                  out_tag
);

   localparam int               NT      = NUM_TERMS + 1;
   localparam logic [EXP_W-1:0] NEG_INF = {1'b1, {(EXP_W-1){1'b0}}};

   typedef struct packed {
      logic [NT-1:0][EXP_W-1:0] exps;
      logic [NT-1:0]            zero;
      logic                     fmt_err;
      logic [TAG_W-1:0]         tag;
   } stage_t;

   logic [3:1]              r_vld;
   logic                    w_rdy2, w_rdy3;
   stage_t                  w_s1, r_s1, r_s2;
   logic [EXP_W-1:0]        w_bias, w_s2_max, r_s2_max, w_d;
   logic                    w_tf32;
   logic [NT-1:0][SHIFT_W-1:0] w_shift;
   logic [NT-1:0]           w_drop;

   assign w_rdy3    = !r_vld[3] || out_ready;
   assign w_rdy2    = !r_vld[2] || w_rdy3;
   assign in_ready  = !r_vld[1] || w_rdy2;
   assign out_valid = r_vld[3];

   // S1: biased product exponents; zero, TF32 odd lanes and bad formats collapse to NEG_INF
   always_comb begin
      w_s1         = '0;
      w_s1.fmt_err = !fmt_ok(in_fmt);
      w_s1.tag     = in_tag;
      w_bias       = EXP_W'(bias_of(in_fmt, W, WA));
      w_tf32       = (in_fmt == TCU_TF32);
      for (int i = 0; i < NUM_TERMS; i++) begin
         w_s1.zero[i] = in_zero[i] | w_s1.fmt_err | (w_tf32 & i[0]);
         w_s1.exps[i] = w_s1.zero[i] ? NEG_INF
                      : EXP_W'($signed(in_ea[i])) + EXP_W'($signed(in_eb[i])) + w_bias;
      end
      w_s1.zero[NUM_TERMS] = in_c_zero | w_s1.fmt_err;
      w_s1.exps[NUM_TERMS] = w_s1.zero[NUM_TERMS] ? NEG_INF
                           : EXP_W'(in_c_exp) + EXP_W'(WA - W);
   end

   vx_tcu_drl_exp_max_tree #(.N(NT), .EXP_W(EXP_W)) u_max (
      .i_exps (r_s1.exps),
      .o_max  (w_s2_max)
   );

   // S3: distance from max; anything past the window is dropped and parked at shift=WA
   always_comb begin
      w_shift = '0;
      w_drop  = '0;
      w_d     = '0;
      for (int i = 0; i < NT; i++) begin
         w_d = r_s2_max - r_s2.exps[i];
         if (r_s2.exps[i] == NEG_INF || w_d >= EXP_W'(WA)) begin
            w_drop[i]  = 1'b1;
            w_shift[i] = SHIFT_W'(WA);
         end else begin
            w_shift[i] = w_d[SHIFT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld        <= '0;
         r_s1         <= '0;
         r_s2         <= '0;
         r_s2_max     <= NEG_INF;
         out_max_exp  <= NEG_INF;
         out_shift    <= '0;
         out_drop     <= '0;
         out_all_zero <= 1'b0;
         out_fmt_err  <= 1'b0;
         out_tag      <= '0;
      end else begin
         if (in_ready) r_vld[1] <= in_valid;
         if (w_rdy2)   r_vld[2] <= r_vld[1];
         if (w_rdy3)   r_vld[3] <= r_vld[2];
         if (in_valid && in_ready) r_s1 <= w_s1;
         if (r_vld[1] && w_rdy2) begin
            r_s2     <= r_s1;
            r_s2_max <= w_s2_max;
         end
         if (r_vld[2] && w_rdy3) begin
            out_max_exp  <= r_s2_max;
            out_shift    <= w_shift;
            out_drop     <= w_drop;
            out_all_zero <= &r_s2.zero;
            out_fmt_err  <= r_s2.fmt_err;
            out_tag      <= r_s2.tag;
         end
      end
   end

endmodule

// File: tb/tb_vx_tcu_drl_exp_align.sv
// Directed bench for the exponent-align pipeline: formats, zero/bad-format cases, backpressure, reset.
module tb_vx_tcu_drl_exp_align;

   localparam int NT = 8;
   localparam int EW = 10;
   localparam int SW = 6;
   localparam int TW = 8;
   localparam logic [EW-1:0] NI = 10'h200;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [2:0]              in_fmt = 3'd0;
   logic [NT-1:0][7:0]      in_ea = '0;
   logic [NT-1:0][7:0]      in_eb = '0;
   logic [NT-1:0]           in_zero = '0;
   logic [7:0]              in_c_exp = 8'd0;
   logic                    in_c_zero = 1'b0;
   logic [TW-1:0]           in_tag = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [EW-1:0]           out_max_exp;
   logic [NT:0][SW-1:0]     out_shift;
   logic [NT:0]             out_drop;
   logic                    out_all_zero;
   logic                    out_fmt_err;
   logic [TW-1:0]           out_tag;

   int checks = 0;
   int fails  = 0;
   logic [NT:0][SW-1:0] xs;

   vx_tcu_drl_exp_align dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_ea(in_ea), .in_eb(in_eb), .in_zero(in_zero),
      .in_c_exp(in_c_exp), .in_c_zero(in_c_zero), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_max_exp(out_max_exp),
      .out_shift(out_shift), .out_drop(out_drop), .out_all_zero(out_all_zero),
      .out_fmt_err(out_fmt_err), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   // drive one packet from the current in_* fields and hold it until accepted
   task automatic send(input logic [2:0] f, input logic [7:0] tag);
      @(negedge clk);
      in_fmt = f; in_tag = tag; in_valid = 1'b1;
      #1;
      for (int k = 0; k < 20 && !in_ready; k++) begin
         @(negedge clk); #1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 10);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0)   begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_max_exp !== NI)   begin fails++; $display("FAIL reset_max got=%h exp=%h", out_max_exp, NI); end
      checks++; if (out_shift !== '0)     begin fails++; $display("FAIL reset_shift got=%h exp=0", out_shift); end
      checks++; if ({out_drop, out_all_zero, out_fmt_err, out_tag} !== '0)
         begin fails++; $display("FAIL reset_misc drop=%h az=%b fe=%b tag=%h exp all 0", out_drop, out_all_zero, out_fmt_err, out_tag); end
      checks++; if (in_ready !== 1'b1)    begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      reset_n = 1'b1;
   endtask

   task automatic test_fp16();
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < NT; i++) begin in_ea[i] = 8'd15; in_eb[i] = 8'd15; end
      in_zero = '0; in_c_zero = 1'b1; in_c_exp = 8'd0;
      send(3'd1, 8'h11);
      wait_out(lat);
      for (int i = 0; i <= NT; i++) xs[i] = (i == NT) ? 6'd28 : 6'd0;
      checks++; if (lat != 3)                begin fails++; $display("FAIL fp16_latency got=%0d exp=3", lat); end
      checks++; if (out_max_exp !== 10'd130) begin fails++; $display("FAIL fp16_max got=%0d exp=130", out_max_exp); end
      checks++; if (out_shift !== xs)        begin fails++; $display("FAIL fp16_shift got=%h exp=%h", out_shift, xs); end
      checks++; if (out_drop !== 9'h100)     begin fails++; $display("FAIL fp16_drop got=%h exp=100", out_drop); end
      checks++; if ({out_all_zero, out_fmt_err} !== 2'b00) begin fails++; $display("FAIL fp16_flags got=%b%b exp=00", out_all_zero, out_fmt_err); end
      checks++; if (out_tag !== 8'h11)       begin fails++; $display("FAIL fp16_tag got=%h exp=11", out_tag); end
   endtask

   task automatic test_bf16();
      int lat;
      in_ea = '0; in_eb = '0;
      in_ea[0] = 8'd127; in_eb[0] = 8'd127;
      in_ea[1] = 8'd112; in_eb[1] = 8'd112;
      in_zero = 8'hFC; in_c_zero = 1'b1;
      send(3'd2, 8'h22);
      wait_out(lat);
      for (int i = 0; i <= NT; i++) xs[i] = (i == 0) ? 6'd0 : 6'd28;
      checks++; if (out_max_exp !== 10'd130) begin fails++; $display("FAIL bf16_max got=%0d exp=130", out_max_exp); end
      checks++; if (out_shift !== xs)        begin fails++; $display("FAIL bf16_shift got=%h exp=%h", out_shift, xs); end
      checks++; if (out_drop !== 9'h1FE)     begin fails++; $display("FAIL bf16_drop got=%h exp=1fe", out_drop); end
   endtask

   task automatic test_fp8_bf8_tf32();
      int lat;
      in_ea = '0; in_eb = '0;
      in_ea[0] = 8'd7; in_eb[0] = 8'd7;
      in_zero = 8'hFE; in_c_zero = 1'b0; in_c_exp = 8'd120;
      send(3'd3, 8'h33);
      wait_out(lat);
      for (int i = 0; i <= NT; i++) xs[i] = (i == 0) ? 6'd0 : (i == NT) ? 6'd8 : 6'd28;
      checks++; if (out_max_exp !== 10'd131) begin fails++; $display("FAIL fp8_max got=%0d exp=131", out_max_exp); end
      checks++; if (out_shift !== xs)        begin fails++; $display("FAIL fp8_shift got=%h exp=%h", out_shift, xs); end
      checks++; if (out_drop !== 9'h0FE)     begin fails++; $display("FAIL fp8_drop got=%h exp=0fe", out_drop); end

      in_ea[0] = 8'd15; in_eb[0] = 8'd15; in_c_zero = 1'b1;
      send(3'd4, 8'h44);
      wait_out(lat);
      checks++; if (out_max_exp !== 10'd131) begin fails++; $display("FAIL bf8_max got=%0d exp=131", out_max_exp); end
      checks++; if (out_drop !== 9'h1FE)     begin fails++; $display("FAIL bf8_drop got=%h exp=1fe", out_drop); end

      for (int i = 0; i < NT; i++) begin in_ea[i] = 8'd127; in_eb[i] = 8'd127; end
      in_ea[2] = 8'd125; in_eb[2] = 8'd125;
      in_zero = '0; in_c_zero = 1'b1;
      send(3'd5, 8'h55);
      wait_out(lat);
      for (int i = 0; i <= NT; i++) xs[i] = (i == NT || i % 2 == 1) ? 6'd28 : (i == 2) ? 6'd4 : 6'd0;
      checks++; if (out_max_exp !== 10'd130) begin fails++; $display("FAIL tf32_max got=%0d exp=130", out_max_exp); end
      checks++; if (out_shift !== xs)        begin fails++; $display("FAIL tf32_shift got=%h exp=%h", out_shift, xs); end
      checks++; if (out_drop !== 9'h1AA)     begin fails++; $display("FAIL tf32_drop got=%h exp=1aa", out_drop); end
   endtask

   task automatic test_zero_fmt();
      int lat;
      for (int i = 0; i < NT; i++) begin in_ea[i] = 8'd15; in_eb[i] = 8'd15; end
      in_zero = 8'hFF; in_c_zero = 1'b1;
      send(3'd1, 8'h66);
      wait_out(lat);
      for (int i = 0; i <= NT; i++) xs[i] = 6'd28;
      checks++; if (out_all_zero !== 1'b1)   begin fails++; $display("FAIL zero_all got=%b exp=1", out_all_zero); end
      checks++; if (out_max_exp !== NI)      begin fails++; $display("FAIL zero_max got=%h exp=200", out_max_exp); end
      checks++; if (out_drop !== 9'h1FF)     begin fails++; $display("FAIL zero_drop got=%h exp=1ff", out_drop); end
      checks++; if (out_shift !== xs)        begin fails++; $display("FAIL zero_shift got=%h exp=%h", out_shift, xs); end
      checks++; if (out_fmt_err !== 1'b0)    begin fails++; $display("FAIL zero_fmt_err got=%b exp=0", out_fmt_err); end

      in_zero = '0; in_c_zero = 1'b0; in_c_exp = 8'd100;
      send(3'd7, 8'h77);
      wait_out(lat);
      checks++; if (out_fmt_err !== 1'b1)    begin fails++; $display("FAIL badfmt_err got=%b exp=1", out_fmt_err); end
      checks++; if (out_all_zero !== 1'b1)   begin fails++; $display("FAIL badfmt_all got=%b exp=1", out_all_zero); end
      checks++; if (out_max_exp !== NI)      begin fails++; $display("FAIL badfmt_max got=%h exp=200", out_max_exp); end
      checks++; if (out_drop !== 9'h1FF)     begin fails++; $display("FAIL badfmt_drop got=%h exp=1ff", out_drop); end
   endtask

   task automatic test_backpressure();
      int sent, rcv, acc_stall;
      logic acc;
      logic [TW-1:0] snap_tag;
      logic [EW-1:0] snap_max;
      sent = 0; rcv = 0; acc_stall = 0;
      snap_tag = '0; snap_max = '0;
      in_ea = '0; in_eb = '0; in_zero = 8'hFE; in_c_zero = 1'b1; in_fmt = 3'd1;
      for (int c = 0; c < 40 && rcv < 6; c++) begin
         @(negedge clk);
         out_ready = (c >= 5);
         in_valid  = (sent < 6);
         in_ea[0]  = 8'(10 + sent);
         in_eb[0]  = 8'(10 + sent);
         in_tag    = 8'(sent);
         #1;
         acc = in_valid && in_ready;
         if (c == 3) begin
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
            snap_tag = out_tag; snap_max = out_max_exp;
         end
         if (c == 4) begin
            checks++; if ({out_valid, out_tag, out_max_exp} !== {1'b1, snap_tag, snap_max})
               begin fails++; $display("FAIL bp_hold got v=%b tag=%h max=%0d exp v=1 tag=%h max=%0d", out_valid, out_tag, out_max_exp, snap_tag, snap_max); end
         end
         if (out_valid && out_ready) begin
            checks++; if (out_tag !== 8'(rcv)) begin fails++; $display("FAIL bp_tag got=%0d exp=%0d", out_tag, rcv); end
            checks++; if (out_max_exp !== 10'(120 + 2 * rcv)) begin fails++; $display("FAIL bp_max got=%0d exp=%0d", out_max_exp, 120 + 2 * rcv); end
            rcv++;
         end
         @(posedge clk);
         if (acc) begin
            sent++;
            if (c < 5) acc_stall++;
         end
      end
      #1 in_valid = 1'b0;
      checks++; if (acc_stall != 3) begin fails++; $display("FAIL bp_accepts_stalled got=%0d exp=3", acc_stall); end
      checks++; if (rcv != 6)       begin fails++; $display("FAIL bp_received got=%0d exp=6", rcv); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_midstream();
      int lat;
      out_ready = 1'b0;
      in_ea = '0; in_eb = '0; in_zero = 8'hFE; in_c_zero = 1'b1;
      in_ea[0] = 8'd20; in_eb[0] = 8'd20;
      send(3'd1, 8'hA0);
      send(3'd1, 8'hA1);
      send(3'd1, 8'hA2);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_release_valid got=%b exp=0", out_valid); end
      in_ea[0] = 8'd12; in_eb[0] = 8'd12;
      send(3'd1, 8'h5A);
      wait_out(lat);
      checks++; if (lat != 3)            begin fails++; $display("FAIL rst_new_latency got=%0d exp=3", lat); end
      checks++; if (out_tag !== 8'h5A)   begin fails++; $display("FAIL rst_new_tag got=%h exp=5a", out_tag); end
      checks++; if (out_max_exp !== 10'd124) begin fails++; $display("FAIL rst_new_max got=%0d exp=124", out_max_exp); end
   endtask

   initial begin
      test_reset();
      test_fp16();
      test_bf16();
      test_fp8_bf8_tf32();
      test_zero_fmt();
      test_backpressure();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
